// File: rtl/bht_ctrl.sv
// rtl/bht_ctrl.sv - branch history table controller (2-bit counters, staged update with bypass, optional BHT_STATS_EN counters)
module bht_ctrl #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_VAL = 2'b01
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_clr,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic        o_ready,
  input  logic        i_upd_vld,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic        i_upd_mispred,
  output logic [31:0] o_upd_cnt,
  output logic [31:0] o_miss_cnt
);

  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] init_idx;
  logic [IDX_W-1:0] init_idx_nxt;

  logic [1:0]       tbl [DEPTH];

  logic             stage_vld;
  logic [IDX_W-1:0] stage_idx;
  logic [1:0]       stage_val;

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_old;
  logic [1:0]       upd_new;
  logic             upd_acc;

  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  logic [1:0]       tbl_wdata;

  logic             unused_pc_bits;

  assign lk_idx  = i_if_pc[IDX_W+1:2];
  assign upd_idx = i_upd_pc[IDX_W+1:2];

  // Only the index field of each PC selects a counter.
  assign unused_pc_bits = &{1'b0, i_if_pc[31:IDX_W+2], i_if_pc[1:0],
                            i_upd_pc[31:IDX_W+2], i_upd_pc[1:0]};

  // A clear request always wins over a resolved branch in the same cycle.
  assign upd_acc = (state == ST_RUN) && i_upd_vld && !i_clr;

  // State and init-sweep index; INIT is entered out of reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else begin
      state    <= state_nxt;
      init_idx <= init_idx_nxt;
    end
  end

  // Next state: sweep all entries in INIT, return to INIT on clear.
  always_comb begin
    state_nxt    = state;
    init_idx_nxt = init_idx;
    o_ready      = 1'b0;
    case (state)
      ST_INIT: begin
        if (i_clr) begin
          init_idx_nxt = '0;
        end else begin
          init_idx_nxt = init_idx + 1'b1;
          if (&init_idx) begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        o_ready = 1'b1;
        if (i_clr) begin
          state_nxt    = ST_INIT;
          init_idx_nxt = '0;
        end
      end
      default: begin
        state_nxt    = ST_INIT;
        init_idx_nxt = '0;
      end
    endcase
  end

  // Chained read: a pending staged write to the same entry is newer than the table.
  always_comb begin
    upd_old = tbl[upd_idx];
    if (stage_vld && (stage_idx == upd_idx)) begin
      upd_old = stage_val;
    end
    if (i_upd_taken) begin
      upd_new = (upd_old == 2'b11) ? upd_old : upd_old + 2'b01;
    end else begin
      upd_new = (upd_old == 2'b00) ? upd_old : upd_old - 2'b01;
    end
  end

  // Single update stage; a clear or reset discards whatever is pending.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stage_vld <= 1'b0;
      stage_idx <= '0;
      stage_val <= '0;
    end else begin
      stage_vld <= upd_acc;
      if (upd_acc) begin
        stage_idx <= upd_idx;
        stage_val <= upd_new;
      end
    end
  end

  // One write port shared by the init sweep and the retiring staged update.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = stage_idx;
    tbl_wdata = stage_val;
    if (state == ST_INIT) begin
      tbl_we    = 1'b1;
      tbl_waddr = init_idx;
      tbl_wdata = INIT_VAL;
    end else if (stage_vld) begin
      tbl_we = 1'b1;
    end
  end

  // Counter array; contents are defined only by the init sweep.
  always_ff @(posedge i_clk) begin
    if (tbl_we) begin
      tbl[tbl_waddr] <= tbl_wdata;
    end
  end

  // Prediction with bypass from the stage register; forced low until RUN.
  always_comb begin
    o_pred_taken = 1'b0;
    if (state == ST_RUN) begin
      if (stage_vld && (stage_idx == lk_idx)) begin
        o_pred_taken = stage_val[1];
      end else begin
        o_pred_taken = tbl[lk_idx][1];
      end
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] upd_cnt;
  logic [31:0] miss_cnt;

  // Saturating statistics; survive a clear, only reset zeroes them.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      upd_cnt  <= '0;
      miss_cnt <= '0;
    end else if (upd_acc) begin
      if (upd_cnt != 32'hFFFF_FFFF) begin
        upd_cnt <= upd_cnt + 32'd1;
      end
      if (i_upd_mispred && (miss_cnt != 32'hFFFF_FFFF)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  assign o_upd_cnt  = upd_cnt;
  assign o_miss_cnt = miss_cnt;
`else
  logic unused_mispred;

  assign unused_mispred = i_upd_mispred;
  assign o_upd_cnt      = 32'd0;
  assign o_miss_cnt     = 32'd0;
`endif

endmodule

// File: tb/tb_bht_ctrl.sv
// tb/tb_bht_ctrl.sv - self-checking bench for bht_ctrl against a behavioural counter-table model
module tb_bht_ctrl;

  logic        i_clk;
  logic        rst_n;
  logic        clr;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ready;
  logic        upd_vld;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_mispred;
  logic [31:0] upd_cnt;
  logic [31:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  // Model: logical counter per entry, cycles left in INIT, statistics.
  int m_cnt [64];
  int m_init_left;
  int m_upd;
  int m_miss;

  bht_ctrl dut (
    .i_clk        (i_clk),
    .i_rstn       (rst_n),
    .i_clr        (clr),
    .i_if_pc      (if_pc),
    .o_pred_taken (pred_taken),
    .o_ready      (ready),
    .i_upd_vld    (upd_vld),
    .i_upd_pc     (upd_pc),
    .i_upd_taken  (upd_taken),
    .i_upd_mispred(upd_mispred),
    .o_upd_cnt    (upd_cnt),
    .o_miss_cnt   (miss_cnt)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic logic m_pred(input logic [31:0] pc);
    return (m_init_left == 0) && (m_cnt[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p      = $urandom;
    p[7:2] = 6'($urandom_range(0, 3));
    return p;
  endfunction

  task automatic model_reset();
    m_init_left = 64;
    for (int i = 0; i < 64; i++) m_cnt[i] = 1;
    m_upd  = 0;
    m_miss = 0;
  endtask

  task automatic idle_in();
    clr         = 1'b0;
    upd_vld     = 1'b0;
    upd_pc      = 32'h0;
    upd_taken   = 1'b0;
    upd_mispred = 1'b0;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic t, input logic m);
    upd_vld     = v;
    upd_pc      = pc;
    upd_taken   = t;
    upd_mispred = m;
  endtask

  // One rising edge; the model consumes the inputs the DUT saw at that edge.
  task automatic tick();
    @(posedge i_clk);
    if (m_init_left == 0) begin
      if (clr) begin
        m_init_left = 64;
        for (int i = 0; i < 64; i++) m_cnt[i] = 1;
      end else if (upd_vld) begin
        if (upd_taken) m_cnt[idx_of(upd_pc)] = (m_cnt[idx_of(upd_pc)] == 3) ? 3 : m_cnt[idx_of(upd_pc)] + 1;
        else           m_cnt[idx_of(upd_pc)] = (m_cnt[idx_of(upd_pc)] == 0) ? 0 : m_cnt[idx_of(upd_pc)] - 1;
        m_upd++;
        if (upd_mispred) m_miss++;
      end
    end else begin
      if (clr) m_init_left = 64;
      else     m_init_left--;
    end
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_in();
    model_reset();
    repeat (2) @(posedge i_clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic run_init();
    for (int k = 0; k < 64; k++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_in();
    if_pc = 32'h100;
    #3;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred got=%b exp=0", pred_taken); end
    total++; if (upd_cnt !== 32'd0) begin bad++; $display("FAIL reset_upd_cnt got=%0d exp=0", upd_cnt); end
    total++; if (miss_cnt !== 32'd0) begin bad++; $display("FAIL reset_miss_cnt got=%0d exp=0", miss_cnt); end
    do_reset();
    for (int k = 1; k <= 63; k++) begin
      tick();
      #1;
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL init_ready cycle=%0d got=%b exp=0", k, ready); end
    end
    tick();
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL init_done_ready got=%b exp=1", ready); end
    for (int k = 0; k < 8; k++) begin
      if_pc = $urandom;
      #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL init_pred pc=%h got=%b exp=0", if_pc, pred_taken); end
    end
  endtask

  task automatic test_single_update();
    if_pc = 32'h0;
    set_upd(1'b1, 32'h100, 1'b1, 1'b0);
    tick();
    idle_in();
    if_pc = 32'h100;
    #1;
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL bypass_pred got=%b exp=1", pred_taken); end
    tick();
    tick();
    #1;
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL table_pred got=%b exp=1", pred_taken); end
    if_pc = 32'h104;
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL neighbour_pred got=%b exp=0", pred_taken); end
  endtask

  task automatic test_saturate_chain();
    for (int k = 0; k < 5; k++) begin set_upd(1'b1, 32'h104, 1'b1, 1'b0); tick(); end
    idle_in();
    if_pc = 32'h104;
    #1;
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL sat_high_pred got=%b exp=1", pred_taken); end
    for (int k = 0; k < 2; k++) begin set_upd(1'b1, 32'h104, 1'b0, 1'b0); tick(); end
    idle_in();
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL sat_down_pred got=%b exp=0", pred_taken); end
    set_upd(1'b1, 32'h104, 1'b1, 1'b0);
    tick();
    idle_in();
    tick();
    #1;
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL sat_wnt_check got=%b exp=1", pred_taken); end
    for (int k = 0; k < 2; k++) begin set_upd(1'b1, 32'h10C, 1'b0, 1'b0); tick(); end
    for (int k = 0; k < 2; k++) begin set_upd(1'b1, 32'h10C, 1'b1, 1'b0); tick(); end
    idle_in();
    if_pc = 32'h10C;
    #1;
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL chain_pred got=%b exp=1", pred_taken); end
    tick();
    tick();
    #1;
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL chain_table_pred got=%b exp=1", pred_taken); end
  endtask

  task automatic test_same_cycle();
    set_upd(1'b1, 32'h108, 1'b1, 1'b0);
    if_pc = 32'h108;
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL same_cycle_pred got=%b exp=0", pred_taken); end
    tick();
    idle_in();
    #1;
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL next_cycle_pred got=%b exp=1", pred_taken); end
  endtask

  task automatic test_clear();
    for (int k = 0; k < 2; k++) begin set_upd(1'b1, 32'h100, 1'b1, 1'b0); tick(); end
    idle_in();
    clr = 1'b1;
    set_upd(1'b1, 32'h100, 1'b1, 1'b0);
    if_pc = 32'h100;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL clr_ready_before got=%b exp=1", ready); end
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL clr_trained_pred got=%b exp=1", pred_taken); end
    tick();
    idle_in();
    for (int k = 0; k < 64; k++) begin
      #1;
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL clr_ready_low cycle=%0d got=%b exp=0", k, ready); end
      tick();
    end
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL clr_ready_back got=%b exp=1", ready); end
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL clr_pred_after got=%b exp=0", pred_taken); end
  endtask

  task automatic test_clr_in_init();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 63; k++) tick();
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL init_restart_ready got=%b exp=0", ready); end
    tick();
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL init_restart_done got=%b exp=1", ready); end
  endtask

  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 64; k++) begin
      set_upd(k < 10, rand_pc(), 1'b1, 1'b1);
      tick();
    end
    idle_in();
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL stats_ready got=%b exp=1", ready); end
    for (int k = 0; k < 10; k++) begin
      set_upd(1'b1, rand_pc(), 1'($urandom_range(0, 1)), (k == 1) || (k == 4) || (k == 7));
      tick();
    end
    idle_in();
    #1;
`ifdef BHT_STATS_EN
    total++; if (upd_cnt !== 32'd10) begin bad++; $display("FAIL stats_upd got=%0d exp=10", upd_cnt); end
    total++; if (miss_cnt !== 32'd3) begin bad++; $display("FAIL stats_miss got=%0d exp=3", miss_cnt); end
`else
    total++; if (upd_cnt !== 32'd0) begin bad++; $display("FAIL stats_off_upd got=%0d exp=0", upd_cnt); end
    total++; if (miss_cnt !== 32'd0) begin bad++; $display("FAIL stats_off_miss got=%0d exp=0", miss_cnt); end
`endif
    clr = 1'b1;
    set_upd(1'b1, 32'h100, 1'b1, 1'b1);
    tick();
    idle_in();
    run_init();
    #1;
`ifdef BHT_STATS_EN
    total++; if (upd_cnt !== 32'd10) begin bad++; $display("FAIL stats_clr_upd got=%0d exp=10", upd_cnt); end
    total++; if (miss_cnt !== 32'd3) begin bad++; $display("FAIL stats_clr_miss got=%0d exp=3", miss_cnt); end
`else
    total++; if (upd_cnt !== 32'd0) begin bad++; $display("FAIL stats_off_clr_upd got=%0d exp=0", upd_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    set_upd(1'b1, 32'h110, 1'b1, 1'b0);
    tick();
    idle_in();
    if_pc = 32'h110;
    #1;
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL mid_pre_pred got=%b exp=1", pred_taken); end
    rst_n = 1'b0;
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", ready); end
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL mid_rst_pred got=%b exp=0", pred_taken); end
    total++; if (upd_cnt !== 32'd0) begin bad++; $display("FAIL mid_rst_upd_cnt got=%0d exp=0", upd_cnt); end
    do_reset();
    run_init();
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after got=%b exp=1", ready); end
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL mid_pred_after got=%b exp=0", pred_taken); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      clr = ($urandom_range(0, 59) == 0);
      set_upd(1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if_pc = ($urandom_range(0, 2) == 0) ? {$urandom, upd_pc[7:0]} : rand_pc();
      #1;
      total++; if (pred_taken !== m_pred(if_pc)) begin bad++; $display("FAIL rand_pred cycle=%0d pc=%h got=%b exp=%b", k, if_pc, pred_taken, m_pred(if_pc)); end
      total++; if (ready !== (m_init_left == 0)) begin bad++; $display("FAIL rand_ready cycle=%0d got=%b exp=%b", k, ready, m_init_left == 0); end
      tick();
    end
    idle_in();
    #1;
`ifdef BHT_STATS_EN
    total++; if (upd_cnt !== 32'(m_upd)) begin bad++; $display("FAIL rand_upd_cnt got=%0d exp=%0d", upd_cnt, m_upd); end
    total++; if (miss_cnt !== 32'(m_miss)) begin bad++; $display("FAIL rand_miss_cnt got=%0d exp=%0d", miss_cnt, m_miss); end
`else
    total++; if (miss_cnt !== 32'd0) begin bad++; $display("FAIL rand_off_miss got=%0d exp=0", miss_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_update();
    test_saturate_chain();
    test_same_cycle();
    test_clear();
    test_clr_in_init();
    test_stats();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
